// File: rtl/coin_pkg.sv
// Shared constants for the coin input conditioner: channel indices
// and helpers that size the debounce and stuck counters.
package coin_pkg;

    localparam int NICKEL = 0;
    localparam int DIME   = 1;

    localparam int DB_CYCLES_DEF    = 4;
    localparam int STUCK_CYCLES_DEF = 64;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int DB_W_DEF    = cnt_width(DB_CYCLES_DEF);
    localparam int STUCK_W_DEF = cnt_width(STUCK_CYCLES_DEF);

endpackage

// File: rtl/coin_debounce.sv
// One coin channel: 2-flop synchronizer, debounce counter, rising-edge
// event flop and stuck-high (jam) detector.
// Ports: clk, rst_n (async, active-low), raw (async sensor level),
//        rise (one-cycle registered coin event), jam (registered flag).
module coin_debounce
    import coin_pkg::*;
#(
    parameter int DB_CYCLES    = 4,
    parameter int STUCK_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise,
    output logic jam
);

    localparam int DB_W = cnt_width(DB_CYCLES);
    localparam int ST_W = cnt_width(STUCK_CYCLES);

    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES);
    localparam logic [ST_W-1:0] ST_MAX = ST_W'(STUCK_CYCLES);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            db_q, db_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            rise_q, rise_d;
    logic [ST_W-1:0] stuck_q, stuck_d;
    logic            jam_q, jam_d;

    logic            toggle;
    logic [DB_W-1:0] cnt_inc;
    logic [ST_W-1:0] stuck_inc;

    always_comb begin
        sync1_d   = raw;
        sync2_d   = sync1_q;
        db_d      = db_q;
        cnt_d     = '0;
        rise_d    = 1'b0;
        stuck_d   = stuck_q;
        jam_d     = jam_q;
        toggle    = 1'b0;
        cnt_inc   = cnt_q + 1'b1;
        stuck_inc = stuck_q + 1'b1;

        // Counter only runs while the synchronized level disagrees.
        if (sync2_q != db_q) begin
            if (cnt_inc == DB_MAX) begin
                toggle = 1'b1;
            end else begin
                cnt_d = cnt_inc;
            end
        end

        if (toggle) begin
            db_d   = !db_q;
            rise_d = !db_q && !jam_q;
        end

        // Jam tracks how long the accepted level has stayed high.
        if (toggle && db_q) begin
            stuck_d = '0;
            jam_d   = 1'b0;
        end else if (db_q) begin
            if (stuck_q != ST_MAX) begin
                stuck_d = stuck_inc;
            end
            jam_d = (stuck_d == ST_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            stuck_q <= '0;
            jam_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            stuck_q <= stuck_d;
            jam_q   <= jam_d;
        end
    end

    assign rise = rise_q;
    assign jam  = jam_q;

endmodule

// File: rtl/coin_conditioner.sv
// Conditions the nickel and dime sensors into clean one-cycle strobes
// and serializes simultaneous coins so no two strobes overlap.
// Ports: clk, rst_n (async, active-low), nickel_raw, dime_raw (async),
//        nickel, dime (registered strobes), jam[1:0] (dime, nickel).
module coin_conditioner
    import coin_pkg::*;
#(
    parameter int DB_CYCLES    = 4,
    parameter int STUCK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       nickel_raw,
    input  logic       dime_raw,
    output logic       nickel,
    output logic       dime,
    output logic [1:0] jam
);

    logic [1:0] ev;
    logic [1:0] jam_w;

    coin_debounce #(
        .DB_CYCLES   (DB_CYCLES),
        .STUCK_CYCLES(STUCK_CYCLES)
    ) u_nickel (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (nickel_raw),
        .rise (ev[NICKEL]),
        .jam  (jam_w[NICKEL])
    );

    coin_debounce #(
        .DB_CYCLES   (DB_CYCLES),
        .STUCK_CYCLES(STUCK_CYCLES)
    ) u_dime (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (dime_raw),
        .rise (ev[DIME]),
        .jam  (jam_w[DIME])
    );

    logic nickel_q, nickel_d;
    logic dime_q, dime_d;
    logic pend_n_q, pend_n_d;
    logic pend_d_q, pend_d_d;

    // A held coin always goes out before any newly arrived one; with
    // two new coins the dime wins and the nickel waits one cycle.
    always_comb begin
        nickel_d = 1'b0;
        dime_d   = 1'b0;
        pend_n_d = 1'b0;
        pend_d_d = 1'b0;

        if (pend_n_q) begin
            nickel_d = 1'b1;
            pend_d_d = ev[DIME];
        end else if (pend_d_q) begin
            dime_d   = 1'b1;
            pend_n_d = ev[NICKEL];
        end else if (ev[DIME]) begin
            dime_d   = 1'b1;
            pend_n_d = ev[NICKEL];
        end else begin
            nickel_d = ev[NICKEL];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nickel_q <= 1'b0;
            dime_q   <= 1'b0;
            pend_n_q <= 1'b0;
            pend_d_q <= 1'b0;
        end else begin
            nickel_q <= nickel_d;
            dime_q   <= dime_d;
            pend_n_q <= pend_n_d;
            pend_d_q <= pend_d_d;
        end
    end

    assign nickel = nickel_q;
    assign dime   = dime_q;
    assign jam    = jam_w;

endmodule

// File: tb/tb_coin_conditioner.sv
// Self-checking bench for coin_conditioner: directed scenarios plus a
// randomized run against a queue-based behavioural model.
module tb_coin_conditioner;

    localparam int DB = 4;
    localparam int ST = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       nickel_raw = 1'b0;
    logic       dime_raw = 1'b0;
    logic       nickel;
    logic       dime;
    logic [1:0] jam;

    int tests = 0;
    int fails = 0;

    coin_conditioner #(
        .DB_CYCLES   (DB),
        .STUCK_CYCLES(ST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .nickel_raw(nickel_raw),
        .dime_raw  (dime_raw),
        .nickel    (nickel),
        .dime      (dime),
        .jam       (jam)
    );

    always #5 clk = ~clk;

    // Behavioural model: raw history gives the sample seen two edges
    // later; a level is accepted once the last DB samples all disagree
    // with it; coins wait in a FIFO and leave one per cycle.
    logic [1:0] rh[$];
    logic [1:0] sh[$];
    int         coin_q[$];
    logic [1:0] m_db, m_ev, m_jam, m_out;
    int         m_stk[2];

    task automatic model_reset();
        rh.delete();
        sh.delete();
        coin_q.delete();
        m_db = 2'b00;
        m_ev = 2'b00;
        m_jam = 2'b00;
        m_out = 2'b00;
        m_stk[0] = 0;
        m_stk[1] = 0;
    endtask

    task automatic model_step(input logic [1:0] raw);
        logic [1:0] samp;
        logic [1:0] ev_next;
        bit flip;
        bit dbb;
        if (m_ev[1]) coin_q.push_back(1);
        if (m_ev[0]) coin_q.push_back(0);
        m_out = 2'b00;
        if (coin_q.size() > 0) begin
            int c;
            c = coin_q.pop_front();
            m_out[c] = 1'b1;
        end
        rh.push_back(raw);
        samp = (rh.size() >= 3) ? rh[rh.size()-3] : 2'b00;
        if (rh.size() > 3) void'(rh.pop_front());
        sh.push_back(samp);
        if (sh.size() > DB) void'(sh.pop_front());
        ev_next = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            dbb = m_db[ch];
            flip = (sh.size() == DB);
            foreach (sh[i]) if (sh[i][ch] == dbb) flip = 0;
            if (flip && dbb) begin
                m_stk[ch] = 0;
                m_jam[ch] = 1'b0;
            end else if (dbb) begin
                if (m_stk[ch] < ST) m_stk[ch]++;
                m_jam[ch] = (m_stk[ch] == ST);
            end
            if (flip) begin
                if (!dbb && !m_jam[ch]) ev_next[ch] = 1'b1;
                m_db[ch] = !dbb;
            end
        end
        m_ev = ev_next;
    endtask

    task automatic step(input logic n, input logic d);
        @(negedge clk);
        nickel_raw = n;
        dime_raw = d;
        @(posedge clk);
        model_step({d, n});
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        nickel_raw = 1'b0;
        dime_raw = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        nickel_raw = 1'b1;
        dime_raw = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({dime, nickel, jam} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_state got %b want 0000", {dime, nickel, jam});
        end
        do_reset();
        for (int e = 1; e <= 7; e++) step(1'b1, 1'b0);
        tests++;
        if (nickel !== 1'b1) begin
            fails++;
            $display("FAIL pre_async got %b want 1", nickel);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (nickel !== 1'b0) begin
            fails++;
            $display("FAIL async_clear got %b want 0", nickel);
        end
    endtask

    task automatic test_nickel();
        int pulses = 0;
        int first = 0;
        int dimes = 0;
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            step(e <= 20, 1'b0);
            if (nickel) begin
                pulses++;
                if (first == 0) first = e;
            end
            if (dime) dimes++;
        end
        tests++;
        if (pulses !== 1) begin
            fails++;
            $display("FAIL nickel_count got %0d want 1", pulses);
        end
        tests++;
        if (first !== 7) begin
            fails++;
            $display("FAIL nickel_edge got %0d want 7", first);
        end
        tests++;
        if (dimes !== 0) begin
            fails++;
            $display("FAIL nickel_no_dime got %0d want 0", dimes);
        end
    endtask

    task automatic test_glitch_dime();
        int pulses = 0;
        int first = 0;
        int nick = 0;
        logic d;
        do_reset();
        for (int c = 1; c <= 55; c++) begin
            d = (c <= 30) ? (((c - 1) / 2) % 2 == 1) : (c <= 40);
            step(1'b0, d);
            if (dime) begin
                pulses++;
                if (first == 0) first = c;
            end
            if (nickel) nick++;
        end
        tests++;
        if (pulses !== 1) begin
            fails++;
            $display("FAIL glitch_count got %0d want 1", pulses);
        end
        tests++;
        if (first !== 37) begin
            fails++;
            $display("FAIL glitch_edge got %0d want 37", first);
        end
        tests++;
        if (nick !== 0) begin
            fails++;
            $display("FAIL glitch_no_nickel got %0d want 0", nick);
        end
    endtask

    task automatic test_simultaneous();
        int ne = 0;
        int de = 0;
        int nc = 0;
        int dc = 0;
        int both = 0;
        do_reset();
        for (int e = 1; e <= 25; e++) begin
            step(e <= 10, e <= 10);
            if (nickel) begin
                nc++;
                if (ne == 0) ne = e;
            end
            if (dime) begin
                dc++;
                if (de == 0) de = e;
            end
            if (nickel && dime) both++;
        end
        tests++;
        if (de !== 7 || dc !== 1) begin
            fails++;
            $display("FAIL simul_dime got edge %0d n %0d want edge 7 n 1", de, dc);
        end
        tests++;
        if (ne !== 8 || nc !== 1) begin
            fails++;
            $display("FAIL simul_nickel got edge %0d n %0d want edge 8 n 1", ne, nc);
        end
        tests++;
        if (both !== 0) begin
            fails++;
            $display("FAIL simul_overlap got %0d want 0", both);
        end
    endtask

    task automatic test_jam();
        int pulses = 0;
        int first = 0;
        logic [1:0] j69, j70, j100, j105, j106;
        int j0 = 0;
        do_reset();
        for (int e = 1; e <= 120; e++) begin
            step(1'b0, e <= 100);
            if (dime) begin
                pulses++;
                if (first == 0) first = e;
            end
            if (jam[0]) j0++;
            if (e == 69) j69 = jam;
            if (e == 70) j70 = jam;
            if (e == 100) j100 = jam;
            if (e == 105) j105 = jam;
            if (e == 106) j106 = jam;
        end
        tests++;
        if (pulses !== 1 || first !== 7) begin
            fails++;
            $display("FAIL jam_pulse got n %0d edge %0d want n 1 edge 7", pulses, first);
        end
        tests++;
        if (j69[1] !== 1'b0 || j70[1] !== 1'b1) begin
            fails++;
            $display("FAIL jam_set got %b%b want 01", j69[1], j70[1]);
        end
        tests++;
        if (j100[1] !== 1'b1 || j105[1] !== 1'b1) begin
            fails++;
            $display("FAIL jam_hold got %b%b want 11", j100[1], j105[1]);
        end
        tests++;
        if (j106[1] !== 1'b0) begin
            fails++;
            $display("FAIL jam_clear got %b want 0", j106[1]);
        end
        tests++;
        if (j0 !== 0) begin
            fails++;
            $display("FAIL jam_other got %0d want 0", j0);
        end
    endtask

    task automatic test_reset_mid();
        int early = 0;
        int pulses = 0;
        int first = 0;
        do_reset();
        for (int e = 1; e <= 5; e++) begin
            step(1'b1, 1'b0);
            if (nickel) early++;
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests++;
        if ({dime, nickel, jam} !== 4'b0000 || early !== 0) begin
            fails++;
            $display("FAIL midreset got %b early %0d want 0000 early 0",
                     {dime, nickel, jam}, early);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            step(1'b1, 1'b0);
            if (nickel) begin
                pulses++;
                if (first == 0) first = e;
            end
        end
        tests++;
        if (pulses !== 1 || first !== 7) begin
            fails++;
            $display("FAIL midreset_pulse got n %0d edge %0d want n 1 edge 7", pulses, first);
        end
    endtask

    task automatic test_short();
        int pulses = 0;
        int first = 0;
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            step((e <= 3) || (e >= 13 && e <= 22), 1'b0);
            if (nickel) begin
                pulses++;
                if (first == 0) first = e;
            end
        end
        tests++;
        if (pulses !== 1 || first !== 19) begin
            fails++;
            $display("FAIL short_glitch got n %0d edge %0d want n 1 edge 19", pulses, first);
        end
    endtask

    task automatic test_random();
        logic [1:0] lvl = 2'b00;
        int rem[2];
        rem[0] = 0;
        rem[1] = 0;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (rem[ch] == 0) begin
                    lvl[ch] = ~lvl[ch];
                    if ($urandom_range(0, 9) == 0)
                        rem[ch] = int'($urandom_range(60, 90));
                    else
                        rem[ch] = int'($urandom_range(1, 8));
                end
                rem[ch]--;
            end
            step(lvl[0], lvl[1]);
            tests++;
            if ({dime, nickel} !== m_out) begin
                fails++;
                $display("FAIL rand_strobe cyc %0d got %b want %b", cyc, {dime, nickel}, m_out);
            end
            tests++;
            if (jam !== m_jam) begin
                fails++;
                $display("FAIL rand_jam cyc %0d got %b want %b", cyc, jam, m_jam);
            end
            if (cyc == 1500) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                tests++;
                if ({dime, nickel, jam} !== 4'b0000) begin
                    fails++;
                    $display("FAIL rand_reset got %b want 0000", {dime, nickel, jam});
                end
                @(posedge clk);
                #2;
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout tests %0d want completion", tests);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_nickel();
        test_glitch_dime();
        test_simultaneous();
        test_jam();
        test_reset_mid();
        test_short();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/coin_conditioner.md
COIN_CONDITIONER -- requirements
Module: coin_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 4: number of consecutive stable synchronized samples required to accept a level change; legal range 2..255.
REQ-002 Parameter STUCK_CYCLES, default 64: number of cycles a debounced high may persist before the channel is declared jammed; legal range DB_CYCLES+1..65535.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 nickel_raw  input  1  asynchronous, bouncy nickel sensor level; high means a coin is present.
REQ-006 dime_raw  input  1  asynchronous, bouncy dime sensor level; high means a coin is present.
REQ-007 nickel  output  1  registered single-cycle strobe per accepted nickel; drives the vending FSM A input.
REQ-008 dime  output  1  registered single-cycle strobe per accepted dime; drives the vending FSM B input.
REQ-009 jam  output  2  registered flag, bit0 nickel channel, bit1 dime channel; high while that channel is jammed.

Function
REQ-010 Each raw input SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-011 Each channel SHALL hold a debounced level and a stability counter; the counter SHALL clear on any cycle where the synchronized value equals the debounced level.
REQ-012 The debounced level SHALL toggle on the edge where the counter would reach DB_CYCLES, and the counter SHALL clear at the same time.
REQ-013 A coin event SHALL be a 0->1 transition of a channel's debounced level; 1->0 transitions SHALL produce no event.
REQ-014 Latency: a raw level held high from the first sampling edge SHALL produce its strobe exactly DB_CYCLES+3 edges later (DB_CYCLES=4 gives edge 7).
REQ-015 Glitches shorter than DB_CYCLES synchronized samples SHALL produce no strobe and no change to the debounced level.
REQ-016 nickel and dime SHALL never be high in the same cycle.
REQ-017 Simultaneous events: dime SHALL be issued first, and the nickel SHALL be held in a 1-deep pending register and issued in the following cycle; no coin SHALL be lost.
REQ-018 A pending nickel SHALL take precedence over a new dime event in the same cycle, and the dime SHALL then be deferred one cycle by the same mechanism.
REQ-019 Each channel SHALL count the cycles its debounced level stays high, saturating at STUCK_CYCLES.
REQ-020 When that count reaches STUCK_CYCLES, the channel's jam bit SHALL set; jam SHALL clear on the edge where the debounced level returns low.
REQ-021 A coin event on a jammed channel SHALL be suppressed. This cannot normally occur, because jam clears only after the level falls.
REQ-022 Any strobe issued before a jam SHALL stand; jam SHALL never retract a strobe.

Reset
REQ-023 On rst_n low, all of the following SHALL go to 0 immediately and independently of clk: synchronizers, debounced levels, counters, pending register, nickel, dime and jam.
REQ-024 Reset deassertion while a raw input is high SHALL be treated as a fresh rising level, yielding one strobe after DB_CYCLES+3 edges if the level stays stable.
REQ-025 Reset asserted mid-debounce or with a nickel pending SHALL discard that event without emitting it.

Structure
REQ-026 Shared package coin_pkg SHALL hold the channel index constants (NICKEL=0, DIME=1) and the counter width localparams derived from DB_CYCLES and STUCK_CYCLES.
REQ-027 One sub-module, coin_debounce, SHALL contain the synchronizer, debounce counter, edge detect and stuck counter for a single channel, instantiated twice.
REQ-028 Arbitration and the pending register SHALL live in the top level.

Verification (DB_CYCLES=4, STUCK_CYCLES=64)
REQ-029 nickel_raw high for 20 cycles, then low -> exactly one nickel pulse, at edge 7; dime stays 0 throughout.
REQ-030 dime_raw toggling high/low every 2 cycles for 30 cycles, then high for 10 cycles -> exactly one dime pulse, 7 edges after the stable high begins.
REQ-031 nickel_raw and dime_raw rising on the same edge, each held 10 cycles -> dime at edge 7, nickel at edge 8, never both high together.
REQ-032 dime_raw held high for 100 cycles -> one dime pulse at edge 7, jam[1]=1 from 64 cycles after the debounced rise; jam[1] clears after release plus debounce; no extra pulses.
REQ-033 nickel_raw high, rst_n pulsed low at cycle 5 and released at cycle 6 -> no pulse before the reset; one nickel pulse 7 edges after the release.
REQ-034 nickel_raw high for 3 cycles only -> no strobe, and the debounced level stays 0.
